// File: rtl/bsg_counter_window_sampler_pkg.sv
// Shared types for the window sampler: controller state and snapshot flag fields.
package bsg_counter_window_sampler_pkg;

  typedef enum logic {
    eRun  = 1'b0,
    ePend = 1'b1
  } cws_state_e;

  // Flag fields that sit above the count in every snapshot word.
  typedef struct packed {
    logic sat;
    logic late;
  } cws_flags_s;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Clear/up event counter paired with the sampler; clear and up together load 1.
module bsg_counter_clear_up #(
  parameter int width_p = 7
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = (clear_i ? '0 : count_q) + width_p'(up_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_window_timer.sv
// Enabled-cycle timer for one window; last_o marks the final cycle of the window.
module bsg_window_timer #(
  parameter int window_p = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clear_i,
  output logic last_o
);

  localparam int timer_width_lp = (window_p > 2) ? $clog2(window_p) : 1;

  logic [timer_width_lp-1:0] timer_q, timer_d;

  assign last_o = (timer_q == timer_width_lp'(window_p - 1));

  // Holds at the terminal value until cleared, so a stalled window stays due.
  always_comb begin
    timer_d = timer_q;
    if (clear_i)              timer_d = '0;
    else if (en_i && !last_o) timer_d = timer_q + timer_width_lp'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) timer_q <= '0;
    else         timer_q <= timer_d;
  end

endmodule

// File: rtl/bsg_counter_window_sampler.sv
// Drives a clear/up counter and snapshots it every window_p enabled cycles into a
// one-entry valid/ready slot; a boundary that meets a full slot waits in PEND.
module bsg_counter_window_sampler
  import bsg_counter_window_sampler_pkg::*;
#(
  parameter int width_p   = 7,
  parameter int max_val_p = 65,
  parameter int window_p  = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               event_i,
  input  logic [width_p-1:0] count_i,
  output logic               counter_up_o,
  output logic               counter_clear_o,
  output logic               v_o,
  output logic [width_p+1:0] data_o,
  input  logic               ready_i
);

  typedef struct packed {
    cws_flags_s         flags;
    logic [width_p-1:0] count;
  } snapshot_s;

  cws_state_e state_q, state_d;
  logic       v_q, v_d;
  snapshot_s  data_q, data_d;

  logic timer_last;
  logic at_max;
  logic boundary;
  logic slot_free;
  logic fire;

  assign at_max    = (count_i == width_p'(max_val_p));
  assign boundary  = (state_q == eRun) && en_i && timer_last;
  assign slot_free = !v_q || ready_i;
  assign fire      = !reset_i && slot_free && (boundary || (state_q == ePend));

  assign counter_up_o    = en_i && event_i && !at_max && !reset_i;
  assign counter_clear_o = fire;

  bsg_window_timer #(
    .window_p(window_p)
  ) timer (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   ((state_q == eRun) && en_i),
    .clear_i(fire),
    .last_o (timer_last)
  );

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    data_d  = data_q;
    if (fire) begin
      state_d          = eRun;
      v_d              = 1'b1;
      data_d.flags.sat  = at_max;
      data_d.flags.late = (state_q == ePend);
      data_d.count      = count_i;
    end else begin
      // No clear here: the counter keeps accumulating while the slot is busy.
      if (boundary)       state_d = ePend;
      if (v_q && ready_i) v_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eRun;
      v_q     <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      data_q  <= data_d;
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_bsg_counter_window_sampler.sv
// Bench for the window sampler with its real counter: event-level model plus pinned literals.
module tb_bsg_counter_window_sampler;

  localparam int W    = 4;
  localparam int MAXV = 65;
  localparam int WD   = 7;

  logic          clk = 1'b0;
  logic          rst, en, ev, rdy;
  logic [WD-1:0] count;
  logic          up, clr, v;
  logic [WD+1:0] data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bsg_counter_window_sampler #(
    .width_p  (WD),
    .max_val_p(MAXV),
    .window_p (W)
  ) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .en_i           (en),
    .event_i        (ev),
    .count_i        (count),
    .counter_up_o   (up),
    .counter_clear_o(clr),
    .v_o            (v),
    .data_o         (data),
    .ready_i        (rdy)
  );

  bsg_counter_clear_up #(
    .width_p(WD)
  ) ctr (
    .clk_i  (clk),
    .reset_i(rst),
    .clear_i(clr),
    .up_i   (up),
    .count_o(count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: events since the last clear, enabled cycles into the window, a due flag
  // for a window that ended while the slot was full, and the output slot itself.
  int            acc = 0;
  int            ecnt = 0;
  bit            due = 0;
  bit            slot_v = 0;
  logic [WD+1:0] slot_d = '0;
  bit            started = 0;

  always @(negedge clk) begin : model
    bit e_up, bnd, free, fire;
    if (started) begin
      check("v_o", 32'(v), 32'(slot_v));
      check("data_o", 32'(data), 32'(slot_d));
      check("count", 32'(count), 32'(acc));
    end
    e_up = !rst && en && ev && (acc != MAXV);
    bnd  = !rst && !due && en && (ecnt == W - 1);
    free = !slot_v || rdy;
    fire = !rst && (bnd || due) && free;
    if (started) begin
      check("counter_up_o", 32'(up), 32'(e_up));
      check("counter_clear_o", 32'(clr), 32'(fire));
    end
    if (rst) begin
      acc = 0; ecnt = 0; due = 0; slot_v = 0; slot_d = '0;
      started = 1;
    end else if (fire) begin
      slot_d = {(acc == MAXV), due, WD'(acc)};
      slot_v = 1;
      acc    = e_up ? 1 : 0;
      ecnt   = 0;
      due    = 0;
    end else begin
      if (slot_v && rdy) slot_v = 0;
      if (bnd) due = 1;
      else if (en && !due) ecnt++;
      if (e_up) acc++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int p;
    rst = 1'b1; en = 1'b1; ev = 1'b1; rdy = 1'b1;
    tick(3);
    check("rst_up", 32'(up), 32'd0);
    check("rst_clear", 32'(clr), 32'd0);
    check("rst_v", 32'(v), 32'd0);
    check("rst_data", 32'(data), 32'd0);

    rst = 1'b0;                       // cycle 0
    tick(3);
    check("first_clear", 32'(clr), 32'd1);
    tick(1);                          // cycle 4
    check("first_v", 32'(v), 32'd1);
    check("first_data", 32'(data), 32'h003);
    rdy = 1'b0;
    tick(10);                         // cycle 14, PEND since cycle 7
    check("held_data", 32'(data), 32'h003);
    check("pend_count", 32'(count), 32'd11);
    rdy = 1'b1;
    tick(1);
    check("late_data", 32'(data), 32'h08B);
    tick(4);
    check("steady_data", 32'(data), 32'h004);

    rdy = 1'b0;
    tick(80);
    check("sat_count", 32'(count), 32'd65);
    check("sat_up", 32'(up), 32'd0);
    rdy = 1'b1;
    tick(1);
    check("sat_data", 32'(data), 32'h1C1);

    ev = 1'b0;
    tick(4);
    check("zero_data", 32'(data), 32'h000);
    check("zero_v", 32'(v), 32'd1);
    tick(4);
    check("zero_data2", 32'(data), 32'h000);

    rdy = 1'b0; ev = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(1);
    check("pend_rst_v", 32'(v), 32'd0);
    rst = 1'b0; rdy = 1'b1;
    tick(4);
    check("post_rst_data", 32'(data), 32'h003);

    for (int i = 0; i < 7; i++) begin
      en = (i % 2 == 0);
      tick(1);
    end
    check("en_toggle_data", 32'(data), 32'h004);
    check("en_toggle_v", 32'(v), 32'd1);
    en = 1'b1;

    p = 100;
    for (int c = 0; c < 4000; c++) begin
      if (c % 60 == 0) begin
        case ($urandom_range(0, 3))
          0:       p = 0;
          1:       p = 30;
          2:       p = 70;
          default: p = 100;
        endcase
      end
      rst = ($urandom_range(0, 399) == 0);
      en  = ($urandom_range(0, 3) != 0);
      ev  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 99) < p);
      tick(1);
    end
    rst = 1'b0; rdy = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
